// File: rtl/shift_pkg.sv
// shift_pkg: shared widths and request/response types for the shift issue/return path
package shift_pkg;
  localparam int DATA_W    = 8;
  localparam int SHAMT_W   = 3;
  localparam int TAG_W_DEF = 4;
  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [SHAMT_W-1:0]   shamt;
    logic                 lr;
    logic                 al;
    logic [TAG_W_DEF-1:0] tag;
  } shift_req_t;
  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [TAG_W_DEF-1:0] tag;
  } shift_rsp_t;
endpackage

// File: rtl/shift_sync_fifo.sv
// shift_sync_fifo: registered-count FIFO, no bypass, head reads 0 when empty
module shift_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic do_wr, do_rd, empty;
  assign empty = cnt == '0;
  assign do_wr = wr && cnt != CW'(DEPTH);
  assign do_rd = rd && !empty;
  assign dout  = empty ? '0 : mem[rptr];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      wptr <= wptr + PW'(do_wr);
      rptr <= rptr + PW'(do_rd);
      cnt  <= cnt + CW'(do_wr) - CW'(do_rd);
    end
  always_ff @(posedge clk)
    if (do_wr && !clr) mem[wptr] <= din;
endmodule

// File: rtl/shift_issue_ctrl.sv
// shift_issue_ctrl: queues tagged shift requests, issues them to a registered
// barrel shifter and returns tagged results in order over valid/ready.
module shift_issue_ctrl
  import shift_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int RES_DEPTH = 2,
  parameter int TAG_W     = TAG_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DATA_W-1:0]  req_data,
  input  logic [SHAMT_W-1:0] req_shamt,
  input  logic               req_lr,
  input  logic               req_al,
  input  logic [TAG_W-1:0]   req_tag,
  output logic [DATA_W-1:0]  sh_din,
  output logic [SHAMT_W-1:0] sh_shamt,
  output logic               sh_lr,
  output logic               sh_al,
  input  logic [DATA_W-1:0]  sh_dout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               busy
);
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    logic               lr;
    logic               al;
    logic [TAG_W-1:0]   tag;
  } req_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } rsp_t;
  req_t req_in, head;
  rsp_t res_in, res_head;
  logic [$clog2(REQ_DEPTH+1)-1:0] req_cnt;
  logic [$clog2(RES_DEPTH+1)-1:0] res_cnt;
  logic [TAG_W-1:0] inflight_tag;
  logic inflight, issue, rsp_pop, push;
  assign req_in    = '{data: req_data, shamt: req_shamt, lr: req_lr, al: req_al, tag: req_tag};
  assign req_ready = req_cnt != ($clog2(REQ_DEPTH+1))'(REQ_DEPTH);
  assign push      = req_valid && req_ready;
  assign rsp_valid = res_cnt != '0;
  assign rsp_pop   = rsp_valid && rsp_ready;
  // A slot is reserved for the in-flight result; a same-cycle pop frees one.
  assign issue = req_cnt != '0 && (int'(res_cnt) + int'(inflight) - int'(rsp_pop)) < RES_DEPTH;
  assign res_in   = '{data: sh_dout, tag: inflight_tag};
  assign sh_din   = head.data;
  assign sh_shamt = head.shamt;
  assign sh_lr    = head.lr;
  assign sh_al    = head.al;
  assign rsp_data = res_head.data;
  assign rsp_tag  = res_head.tag;
  assign busy     = req_cnt != '0 || inflight || res_cnt != '0;
  shift_sync_fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk  (clk),
    .rstn (rstn),
    .clr  (flush),
    .wr   (push),
    .din  (req_in),
    .rd   (issue),
    .dout (head),
    .cnt  (req_cnt)
  );
  shift_sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk  (clk),
    .rstn (rstn),
    .clr  (flush),
    .wr   (inflight),
    .din  (res_in),
    .rd   (rsp_pop),
    .dout (res_head),
    .cnt  (res_cnt)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      inflight     <= 1'b0;
      inflight_tag <= '0;
    end else begin
      inflight     <= issue && !flush;
      inflight_tag <= head.tag;
    end
endmodule
